// File: rtl/fp8_pkg.sv
// Shared FP8 definitions for the operand sequencer: field widths, the
// sequencer state encoding and the default adder latency.
package fp8_pkg;

  localparam int SIGN_W = 1;
  localparam int EXP_W  = 4;
  localparam int MANT_W = 3;
  localparam int FP8_W  = SIGN_W + EXP_W + MANT_W;

  localparam int ADD_LAT_DEFAULT = 1;

  typedef logic [FP8_W-1:0] fp8_t;

  typedef enum logic [2:0] {
    FETCH_A = 3'd0,
    FETCH_B = 3'd1,
    ISSUE   = 3'd2,
    CAPTURE = 3'd3,
    HOLD    = 3'd4
  } seq_state_t;

endpackage

// File: rtl/fp8_operand_sequencer_if.sv
// Byte stream in and captured-sum stream out of the FP8 operand sequencer.
interface fp8_operand_sequencer_if;
  import fp8_pkg::*;

  // Valid/ready: a beat transfers on the rising clk edge where valid && ready
  // are both high; the source keeps data stable while valid && !ready.
  fp8_t in_data;
  logic in_valid;
  logic in_ready;
  fp8_t out_data;
  logic out_valid;
  logic out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/fp8_byte_fifo.sv
// Circular byte FIFO; pointers carry one extra wrap bit so full and empty
// are distinguished without a separate counter.
module fp8_byte_fifo
  import fp8_pkg::*;
#(
  parameter  int FIFO_DEPTH = 4,
  localparam int PTR_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  fp8_t             push_data,
  input  logic             pop,
  output fp8_t             pop_data,
  output logic             full,
  output logic             empty,
  output logic [PTR_W-1:0] count
);

  localparam int IDX_W = PTR_W - 1;

  fp8_t             mem_q [FIFO_DEPTH];
  fp8_t             mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

  assign count    = wr_ptr_q - rd_ptr_q;
  assign full     = (count == PTR_W'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem_q[rd_ptr_q[IDX_W-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[IDX_W-1:0]] = push_data;
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  // Storage is not reset: contents are meaningless once the pointers clear.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/fp8_operand_sequencer.sv
// Pairs incoming FP8 bytes in arrival order, drives them to an external adder
// for ADD_LAT cycles and holds the registered sum until the consumer takes it.
module fp8_operand_sequencer
  import fp8_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADD_LAT    = ADD_LAT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  fp8_operand_sequencer_if.slave    bus,
  output fp8_t                      op_a,
  output fp8_t                      op_b,
  output logic                      op_en,
  input  fp8_t                      add_result,
  output logic                      busy,
  output seq_state_t                state_dbg
);

  localparam logic [2:0] LAST_CNT = 3'(ADD_LAT - 1);

  seq_state_t state_q, state_d;
  fp8_t       op_a_q, op_a_d;
  fp8_t       op_b_q, op_b_d;
  logic [2:0] cnt_q, cnt_d;
  fp8_t       out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;

  logic                        fifo_push;
  logic                        fifo_pop;
  fp8_t                        fifo_head;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  fp8_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (bus.in_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.in_ready  = !fifo_full;
  assign fifo_push     = bus.in_valid && bus.in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign op_a          = op_a_q;
  assign op_b          = op_b_q;
  assign busy          = (state_q != FETCH_A) || (fifo_count != '0);
  assign state_dbg     = state_q;

  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    fifo_pop    = 1'b0;
    op_en       = 1'b0;
    case (state_q)
      FETCH_A: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          op_a_d   = fifo_head;
          state_d  = FETCH_B;
        end
      end
      FETCH_B: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          op_b_d   = fifo_head;
          cnt_d    = '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        op_en = 1'b1;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == LAST_CNT) state_d = CAPTURE;
      end
      CAPTURE: begin
        out_data_d  = add_result;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        // Returning to FETCH_A takes a cycle, so no pop overlaps the hand-off.
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = FETCH_A;
        end
      end
      default: state_d = FETCH_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= FETCH_A;
      op_a_q      <= 8'h00;
      op_b_q      <= 8'h00;
      cnt_q       <= '0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_fp8_operand_sequencer.sv
// Self-checking bench: randomized byte streams against an arrival-order
// pairing model, plus a second instance built with a three-cycle adder.
module tb_fp8_operand_sequencer;
  import fp8_pkg::*;

  localparam int FIFO_DEPTH = 4;
  localparam int ADD_LAT    = 1;
  localparam int ADD_LAT3   = 3;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- DUTs and adder models ----------------
  fp8_operand_sequencer_if bus ();
  fp8_operand_sequencer_if bus3 ();

  fp8_t       op_a, op_b, add_result, op_a3, op_b3, add_result3;
  logic       op_en, busy, op_en3, busy3;
  seq_state_t state_dbg, state_dbg3;

  fp8_operand_sequencer #(.FIFO_DEPTH(FIFO_DEPTH), .ADD_LAT(ADD_LAT)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .op_a(op_a), .op_b(op_b), .op_en(op_en),
    .add_result(add_result), .busy(busy), .state_dbg(state_dbg)
  );

  fp8_operand_sequencer #(.FIFO_DEPTH(FIFO_DEPTH), .ADD_LAT(ADD_LAT3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3), .op_a(op_a3), .op_b(op_b3), .op_en(op_en3),
    .add_result(add_result3), .busy(busy3), .state_dbg(state_dbg3)
  );

  // Stand-in for the FP8 adder: any deterministic function exposes ordering
  // errors, except 1.0 + 1.0 which must give 2.0 (8'h40).
  function automatic fp8_t adder_fn(input fp8_t a, input fp8_t b);
    if (a == 8'h38 && b == 8'h38) return 8'h40;
    return (a ^ 8'h5A) + b;
  endfunction

  // The sum only becomes valid ADD_LAT edges after op_en; earlier it reads 8'hEE.
  fp8_t pipe  [ADD_LAT];
  fp8_t pipe3 [ADD_LAT3];
  always @(posedge clk) begin
    pipe[0]  <= op_en  ? adder_fn(op_a, op_b)   : 8'hEE;
    pipe3[0] <= op_en3 ? adder_fn(op_a3, op_b3) : 8'hEE;
    for (int i = 1; i < ADD_LAT; i++)  pipe[i]  <= pipe[i-1];
    for (int i = 1; i < ADD_LAT3; i++) pipe3[i] <= pipe3[i-1];
  end
  assign add_result  = pipe[ADD_LAT-1];
  assign add_result3 = pipe3[ADD_LAT3-1];

  // ---------------- scoreboard ----------------
  logic [7:0] byte_q[$];
  logic [7:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  fp8_t cur_a, cur_b, prev_od;
  logic prev_ov, prev_or, prev_en;
  int   en_run;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ov = 1'b0; prev_or = 1'b0; prev_en = 1'b0; en_run = 0;
      end else begin
        if (bus.in_valid && bus.in_ready) byte_q.push_back(bus.in_data);
        if (op_en && !prev_en) begin
          check_eq("pair_avail", 32'(byte_q.size() >= 2), 1);
          cur_a = (byte_q.size() > 0) ? byte_q.pop_front() : 8'h00;
          cur_b = (byte_q.size() > 0) ? byte_q.pop_front() : 8'h00;
          exp_q.push_back(adder_fn(cur_a, cur_b));
          en_run = 0;
        end
        if (op_en) begin
          en_run++;
          check_eq("op_a_issue", op_a, cur_a);
          check_eq("op_b_issue", op_b, cur_b);
        end
        if (!op_en && prev_en) begin
          check_eq("op_en_width", en_run, ADD_LAT);
          check_eq("op_a_capture", op_a, cur_a);
          check_eq("op_b_capture", op_b, cur_b);
        end
        if (prev_ov && !prev_or) begin
          check_eq("out_valid_held", bus.out_valid, 1);
          check_eq("out_data_held", bus.out_data, prev_od);
        end
        if (bus.out_valid && bus.out_ready) begin
          check_eq("out_pending", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) check_eq("out_data", bus.out_data, exp_q.pop_front());
        end
        prev_ov = bus.out_valid;
        prev_or = bus.out_ready;
        prev_od = bus.out_data;
        prev_en = op_en;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_byte(input fp8_t d);
    int n;
    n = 0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.in_ready || n >= 200) break;
      n++;
    end
    check_eq("push_accept", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out_valid();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.out_valid) break;
    end
    check_eq("hold_reached", bus.out_valid, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && byte_q.size() == 0 && !busy && !bus.out_valid) break;
    end
    check_eq("drain_busy", busy, 0);
    check_eq("drain_exp", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  fp8_t d6 [6];
  fp8_t a3, b3, got3;
  int   acc, en_cnt, en_first, out_first, ov_seen;
  logic done;

  initial begin : main
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.out_ready = 1'b0;
    bus3.in_valid = 1'b0; bus3.in_data = 8'h00; bus3.out_ready = 1'b0;

    // reset values, during reset and first cycle after release
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", bus.in_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_op_en", op_en, 0);
    check_eq("rst_op_a", op_a, 8'h00);
    check_eq("rst_op_b", op_b, 8'h00);
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_out_data", bus.out_data, 8'h00);
    check_eq("rst_state", state_dbg, FETCH_A);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_in_ready", bus.in_ready, 1);
    check_eq("post_rst_busy", busy, 0);
    @(posedge clk); #1;

    // 1.0 + 1.0
    bus.out_ready = 1'b1;
    push_byte(8'h38);
    push_byte(8'h38);
    wait_drain();
    check_eq("one_plus_one", bus.out_data, 8'h40);

    // gapped arrivals keep arrival-order pairing
    push_byte(8'h11); idle($urandom_range(0, 3));
    push_byte(8'h22); idle($urandom_range(0, 3));
    push_byte(8'h33); idle($urandom_range(0, 3));
    push_byte(8'h44);
    wait_drain();

    // backpressure in HOLD: FIFO fills to its depth, then drains in order
    bus.out_ready = 1'b0;
    push_byte(8'($urandom));
    push_byte(8'($urandom));
    wait_out_valid();
    for (int i = 0; i < 6; i++) d6[i] = 8'($urandom);
    acc = 0;
    bus.in_data  = d6[0];
    bus.in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.in_ready) acc++;
      @(posedge clk); #1;
      if (acc < 6) bus.in_data = d6[acc];
      else bus.in_valid = 1'b0;
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_eq("hold_accepted", acc, FIFO_DEPTH);
    check_eq("hold_in_ready", bus.in_ready, 0);
    check_eq("hold_busy", busy, 1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    for (int i = acc; i < 6; i++) push_byte(d6[i]);
    wait_drain();

    // full FIFO then continuous streaming past several pointer wraps
    bus.out_ready = 1'b0;
    push_byte(8'($urandom));
    push_byte(8'($urandom));
    wait_out_valid();
    for (int i = 0; i < FIFO_DEPTH; i++) push_byte(8'($urandom));
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3 * FIFO_DEPTH; i++) push_byte(8'($urandom));
    wait_drain();

    // random traffic with random consumer stalls
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          idle($urandom_range(0, 2));
          push_byte(8'($urandom));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.out_ready = 1'b1;
    wait_drain();

    // ADD_LAT=3 instance: single pair, op_en width and out_valid timing
    a3 = 8'($urandom); b3 = 8'($urandom);
    bus3.out_ready = 1'b1;
    bus3.in_data = a3; bus3.in_valid = 1'b1;
    @(posedge clk); #1;
    bus3.in_data = b3;
    @(posedge clk); #1;
    bus3.in_valid = 1'b0;
    en_cnt = 0; en_first = -1; out_first = -1; got3 = 8'h00;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (op_en3) begin
        en_cnt++;
        if (en_first < 0) en_first = c;
        check_eq("lat3_op_a", op_a3, a3);
        check_eq("lat3_op_b", op_b3, b3);
      end
      if (bus3.out_valid && out_first < 0) begin
        out_first = c;
        got3 = bus3.out_data;
      end
    end
    @(posedge clk); #1;
    check_eq("lat3_op_en_width", en_cnt, ADD_LAT3);
    check_eq("lat3_out_delay", 32'(out_first - en_first), ADD_LAT3 + 1);
    check_eq("lat3_out_data", got3, adder_fn(a3, b3));

    // reset during ISSUE with bytes still queued
    bus.out_ready = 1'b0;
    push_byte(8'($urandom));
    push_byte(8'($urandom));
    wait_out_valid();
    for (int i = 0; i < FIFO_DEPTH; i++) push_byte(8'($urandom));
    bus.out_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (op_en && (byte_q.size() == 2)) break;
    end
    check_eq("issue_reached", op_en, 1);
    #1;
    rst_n = 1'b0;
    byte_q.delete();
    exp_q.delete();
    @(negedge clk);
    check_eq("midrst_op_en", op_en, 0);
    check_eq("midrst_op_a", op_a, 8'h00);
    check_eq("midrst_op_b", op_b, 8'h00);
    check_eq("midrst_out_valid", bus.out_valid, 0);
    check_eq("midrst_out_data", bus.out_data, 8'h00);
    check_eq("midrst_in_ready", bus.in_ready, 1);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_state", state_dbg, FETCH_A);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ov_seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (bus.out_valid || op_en) ov_seen++;
    end
    check_eq("midrst_no_out", ov_seen, 0);
    check_eq("midrst_idle_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
